sram_access_controller: RTL and testbench
=========================================

// Module: sram_access_controller
// PURPOSE
// Sequences the external 16-bit SRAM on behalf of the MEM stage. Turns one 32-bit LDR/STR
// (mem_read_enable / mem_write_enable from the control unit) into two timed half-word SRAM
// accesses. Holds ready low to freeze the pipeline until the word access completes.
// PARAMETERS
// ADDR_W       18    SRAM half-word address width
// WAIT_CYCLES  3     cycles per half-word phase (P); legal range >= 2
// BASE_ADDR    1024  CPU byte address mapped to SRAM half-word 0
// PORTS
// clk          in    1      pipeline clock, rising edge
// rst          in    1      asynchronous, active-low reset
// wr_en        in    1      store request from MEM stage (level)
// rd_en        in    1      load request from MEM stage (level)
// address      in    32     CPU byte address (ALU result)
// write_data   in    32     store data (Rm value)
// read_data    out   32     load data; valid while ready=1 after a read
// ready        out   1      0 = freeze IF..MEM; 1 = stage may advance
// SRAM_DQ      inout 16     SRAM data bus
// SRAM_ADDR    out   ADDR_W SRAM half-word address
// SRAM_WE_N    out   1      SRAM write strobe, active-low
// SRAM_OE_N    out   1      SRAM output enable, active-low
// BEHAVIOUR
// - Reset (rst=0, async): state=IDLE, counter=0, read_data=0, SRAM_ADDR=0,
//   SRAM_WE_N=1, SRAM_OE_N=1, SRAM_DQ=Z.
// - req = rd_en | wr_en. ready is combinational:
//   ready = (state==DONE) | (state==IDLE & ~req).
// - FSM: IDLE -> LO (on req) -> HI -> DONE -> IDLE.
//   - IDLE latches op (write if wr_en, else read), address, and write_data.
//   - LO and HI each last exactly P cycles, timed by the counter.
//   - DONE lasts 1 cycle.
// - Latency: request seen in cycle 0; ready=0 in cycles 0..2P; ready=1 in cycle 2P+1 (DONE).
// - Address mapping (32-bit unsigned arithmetic):
//   - off = address - BASE_ADDR, wraps modulo 2^32 (no error for address < BASE_ADDR).
//   - SRAM_ADDR = {off[ADDR_W:2], h}, with h=0 in LO and h=1 in HI.
// - Read:
//   - SRAM_OE_N=0 throughout LO and HI; DQ tristated.
//   - read_data[15:0] captured on the last cycle of LO.
//   - read_data[31:16] captured on the last cycle of HI.
//   - read_data holds its value until the next read completes.
// - Write:
//   - DQ driven with write_data[15:0] in LO and write_data[31:16] in HI.
//   - SRAM_WE_N=0 on cycles 1..P-1 of each phase, 1 on the last cycle of the phase.
//     SRAM_ADDR therefore never changes while WE_N=0.
//   - SRAM_OE_N=1.
//   - read_data is unchanged.
// - rd_en & wr_en both high: treated as a write.
// - Request inputs change or drop after IDLE: ignored; the latched op runs to DONE.
// - DONE always returns to IDLE. A back-to-back request from the next instruction starts in
//   the following cycle (one IDLE cycle with ready=0). The same op is never issued twice.
// - Reset during LO/HI: access aborted immediately. Any half-word already written stays in SRAM.
// STRUCTURE
// - Shared header mem_defines.vh:
//   - state encodings IDLE/LO/HI/DONE (2-bit);
//   - BASE_ADDR default;
//   - SRAM width constants.
// - Sub-module sram_phase_counter: load/decrement counter with a 'last' flag; reused per phase.
// - Top level contains the FSM, address/data latches, and the DQ tristate.
// TESTING
// 1. Reset:
//    - rst=0 mid-HI of a write -> next edge: WE_N=1, OE_N=1, DQ=Z, ready=~req, read_data=0.
// 2. STR address=1024, write_data=0xDEADBEEF (P=3):
//    - SRAM_ADDR 0 gets 0xBEEF, SRAM_ADDR 1 gets 0xDEAD;
//    - ready low for 7 cycles, then high for 1 cycle.
// 3. LDR address=1024 after test 2:
//    - read_data=0xDEADBEEF while ready=1; WE_N stays 1 throughout.
// 4. STR address=1032, then LDR address=1032 back-to-back:
//    - SRAM_ADDR 4 and 5 written; one IDLE gap cycle with ready=0; load returns the stored word.
// 5. rd_en=wr_en=1, address=1028:
//    - performed as a write to half-words 2 and 3; read_data unchanged.
// 6. Drop wr_en in LO, and check the WE_N window:
//    - access completes to DONE regardless of wr_en;
//    - WE_N never low when SRAM_ADDR changes (assertion);
//    - address=1020 wraps to SRAM_ADDR {off[18:2]=0x1FFFF, h}.

Source files
------------

// File: rtl/sram_access_controller_pkg.sv
// Shared definitions for the SRAM access controller: FSM state encoding, default
// geometry of the external 16-bit SRAM, and CPU-to-SRAM address arithmetic.
package sram_access_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } ctrl_state_t;

  localparam int          SRAM_DATA_W     = 16;
  localparam int          CPU_DATA_W      = 32;
  localparam int          SRAM_ADDR_W_DEF = 18;
  localparam int          WAIT_CYCLES_DEF = 3;
  localparam logic [31:0] BASE_ADDR_DEF   = 32'd1024;

  // Byte offset of a CPU address inside the SRAM window; wraps modulo 2^32 by design.
  function automatic logic [31:0] sram_byte_offset(input logic [31:0] cpu_addr,
                                                   input logic [31:0] base_addr);
    return cpu_addr - base_addr;
  endfunction

endpackage

// File: rtl/sram_access_controller_phase_counter.sv
// Load/decrement down-counter that times one half-word phase; o_last flags the
// final cycle of the phase (count has reached zero).
module sram_access_controller_phase_counter
  import sram_access_controller_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_value,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_count,
  output logic             o_last
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_value;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_count = r_count;
  assign o_last  = (r_count == '0);

endmodule

// File: rtl/sram_access_controller.sv
// MEM-stage SRAM sequencer: splits one 32-bit load/store into two timed 16-bit
// SRAM accesses (low half, then high half) and holds ready low until the word is done.
module sram_access_controller
  import sram_access_controller_pkg::*;
#(
  parameter int          ADDR_W      = SRAM_ADDR_W_DEF,
  parameter int          WAIT_CYCLES = WAIT_CYCLES_DEF,
  parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [CPU_DATA_W-1:0]  address,
  input  logic [CPU_DATA_W-1:0]  write_data,
  output logic [CPU_DATA_W-1:0]  read_data,
  output logic                   ready,
  inout  logic [SRAM_DATA_W-1:0] SRAM_DQ,
  output logic [ADDR_W-1:0]      SRAM_ADDR,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_OE_N
);

  localparam int CNT_W = $clog2(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] PHASE_LOAD = CNT_W'(WAIT_CYCLES - 1);

  ctrl_state_t r_state;
  ctrl_state_t w_state_next;

  logic                   w_req;
  logic                   w_start;
  logic                   w_lo_to_hi;
  logic                   w_cap_lo;
  logic                   w_cap_hi;
  logic                   w_cnt_load;
  logic                   w_cnt_dec;
  logic                   w_cnt_last;
  logic [CNT_W-1:0]       w_cnt;
  logic                   w_op_write_next;
  logic                   w_in_phase_next;
  logic                   w_cnt_next_zero;
  logic                   w_we_n_next;
  logic                   w_oe_n_next;
  logic                   w_dq_oe_next;
  logic [31:0]            w_off;
  logic [ADDR_W-2:0]      w_word_addr;
  logic                   w_unused_off;

  logic                   r_op_write;
  logic [ADDR_W-2:0]      r_word_addr;
  logic [SRAM_DATA_W-1:0] r_wdata_hi;
  logic [ADDR_W-1:0]      r_sram_addr;
  logic                   r_we_n;
  logic                   r_oe_n;
  logic                   r_dq_oe;
  logic [SRAM_DATA_W-1:0] r_dq_out;
  logic [CPU_DATA_W-1:0]  r_read_data;

  assign w_req       = rd_en | wr_en;
  assign w_off       = sram_byte_offset(address, BASE_ADDR);
  assign w_word_addr = w_off[ADDR_W:2];
  // Byte-lane bits and bits above the SRAM window are intentionally dropped.
  assign w_unused_off = ^{w_off[31:ADDR_W+1], w_off[1:0]};

  sram_access_controller_phase_counter #(
    .CNT_W (CNT_W)
  ) u_phase_cnt (
    .clk          (clk),
    .rst          (rst),
    .i_load       (w_cnt_load),
    .i_load_value (PHASE_LOAD),
    .i_dec        (w_cnt_dec),
    .o_count      (w_cnt),
    .o_last       (w_cnt_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_load   = 1'b0;
    w_cnt_dec    = 1'b0;
    w_start      = 1'b0;
    w_lo_to_hi   = 1'b0;
    w_cap_hi     = 1'b0;
    ready        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        ready = ~w_req;
        if (w_req) begin
          w_state_next = ST_LO;
          w_cnt_load   = 1'b1;
          w_start      = 1'b1;
        end
      end
      ST_LO: begin
        if (w_cnt_last) begin
          w_state_next = ST_HI;
          w_cnt_load   = 1'b1;
          w_lo_to_hi   = 1'b1;
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      ST_HI: begin
        if (w_cnt_last) begin
          w_state_next = ST_DONE;
          w_cap_hi     = ~r_op_write;
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      ST_DONE: begin
        ready        = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    // Strobes are registered from next-state values so they change only on clock edges.
    w_cap_lo        = w_lo_to_hi & ~r_op_write;
    w_op_write_next = (r_state == ST_IDLE) ? wr_en : r_op_write;
    w_in_phase_next = (w_state_next == ST_LO) || (w_state_next == ST_HI);
    w_cnt_next_zero = w_cnt_dec && (w_cnt == CNT_W'(1));
    w_we_n_next     = ~(w_op_write_next & w_in_phase_next & ~w_cnt_next_zero);
    w_oe_n_next     = ~(~w_op_write_next & w_in_phase_next);
    w_dq_oe_next    = w_op_write_next & w_in_phase_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op_write  <= 1'b0;
      r_word_addr <= '0;
      r_wdata_hi  <= '0;
      r_sram_addr <= '0;
      r_we_n      <= 1'b1;
      r_oe_n      <= 1'b1;
      r_dq_oe     <= 1'b0;
      r_dq_out    <= '0;
      r_read_data <= '0;
    end else begin
      r_we_n  <= w_we_n_next;
      r_oe_n  <= w_oe_n_next;
      r_dq_oe <= w_dq_oe_next;
      if (w_start) begin
        r_op_write  <= wr_en;
        r_word_addr <= w_word_addr;
        r_wdata_hi  <= write_data[31:16];
        r_sram_addr <= {w_word_addr, 1'b0};
        r_dq_out    <= write_data[15:0];
      end else if (w_lo_to_hi) begin
        r_sram_addr <= {r_word_addr, 1'b1};
        r_dq_out    <= r_wdata_hi;
      end
      if (w_cap_lo) begin
        r_read_data[15:0] <= SRAM_DQ;
      end
      if (w_cap_hi) begin
        r_read_data[31:16] <= SRAM_DQ;
      end
    end
  end

  assign SRAM_DQ   = r_dq_oe ? r_dq_out : {SRAM_DATA_W{1'bz}};
  assign SRAM_ADDR = r_sram_addr;
  assign SRAM_WE_N = r_we_n;
  assign SRAM_OE_N = r_oe_n;
  assign read_data = r_read_data;

endmodule

// File: tb/tb_sram_access_controller.sv
// Bench for sram_access_controller: behavioural async SRAM, word-level reference
// model, directed scenarios and randomized load/store traffic.
module tb_sram_access_controller;
  import sram_access_controller_pkg::*;

  localparam int          P       = 3;
  localparam int          AW      = 18;
  localparam logic [31:0] BASE    = 32'd1024;
  localparam int          N_WORDS = 1 << (AW - 1);
  localparam int          EXP_LOW = 2 * P + 1;
  localparam int          EXP_WE  = 2 * (P - 1);
  localparam int          EXP_OE  = 2 * P;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [31:0]   address = '0;
  logic [31:0]   write_data = '0;
  logic [31:0]   read_data;
  logic          ready;
  wire  [15:0]   SRAM_DQ;
  logic [AW-1:0] SRAM_ADDR;
  logic          SRAM_WE_N;
  logic          SRAM_OE_N;
  logic          probe = 1'b0;

  bit   [15:0]   sram [0:(1<<AW)-1];
  logic [15:0]   ref_mem [int];
  logic [31:0]   exp_rd = '0;
  int            n_checks = 0;
  int            n_pass = 0;
  int            we_viol = 0;
  logic [AW-1:0] mon_addr = '0;
  logic          mon_we_n = 1'b1;

  sram_access_controller #(
    .ADDR_W      (AW),
    .WAIT_CYCLES (P),
    .BASE_ADDR   (BASE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .SRAM_DQ    (SRAM_DQ),
    .SRAM_ADDR  (SRAM_ADDR),
    .SRAM_WE_N  (SRAM_WE_N),
    .SRAM_OE_N  (SRAM_OE_N)
  );

  always #5 clk = ~clk;

  // External SRAM: drives DQ while OE_N is low, stores DQ while WE_N is low.
  assign SRAM_DQ = (SRAM_OE_N === 1'b0) ? sram[SRAM_ADDR] : (probe ? 16'h0000 : 16'hzzzz);

  always @(negedge clk) begin
    if (SRAM_WE_N === 1'b0) sram[SRAM_ADDR] <= SRAM_DQ;
  end

  always @(negedge clk) begin
    if (rst === 1'b1 && mon_we_n === 1'b0 && SRAM_ADDR !== mon_addr) we_viol <= we_viol + 1;
    mon_addr <= SRAM_ADDR;
    mon_we_n <= SRAM_WE_N;
  end

  function automatic int word_idx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'((off / 32'd4) % N_WORDS);
  endfunction

  function automatic logic [15:0] ref_half(input int h);
    return ref_mem.exists(h) ? ref_mem[h] : 16'h0000;
  endfunction

  task automatic ref_access(input logic wr, input logic [31:0] a, input logic [31:0] d);
    int w;
    w = word_idx(a);
    if (wr) begin
      ref_mem[2*w]     = d[15:0];
      ref_mem[2*w + 1] = d[31:16];
    end else begin
      exp_rd = {ref_half(2*w + 1), ref_half(2*w)};
    end
  endtask

  // Issues one MEM-stage request (called just after a rising edge) and holds it until ready.
  task automatic do_access(input logic wr, input logic rd, input logic [31:0] a,
                           input logic [31:0] d, input int drop_at,
                           output int low, output int we_low, output int oe_low,
                           output logic [31:0] rd_at_done, output bit timeout);
    int cyc;
    bit seen;
    wr_en = wr; rd_en = rd; address = a; write_data = d;
    low = 0; we_low = 0; oe_low = 0; rd_at_done = '0; cyc = 0; seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      if (ready === 1'b1) begin
        seen = 1'b1;
        rd_at_done = read_data;
      end else begin
        low++;
      end
      if (SRAM_WE_N === 1'b0) we_low++;
      if (SRAM_OE_N === 1'b0) oe_low++;
      if (cyc == drop_at) begin wr_en = 1'b0; rd_en = 1'b0; end
      cyc++;
    end
    timeout = !seen;
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
    $display("txn wr=%0b rd=%0b addr=%08h data=%08h ready_low=%0d we_low=%0d oe_low=%0d read_data=%08h",
             wr, rd, a, d, low, we_low, oe_low, rd_at_done);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++; if (ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", ready); else n_pass++;
    n_checks++; if (read_data !== 32'h0) $display("FAIL reset_read_data: got %08h want 0", read_data); else n_pass++;
    n_checks++; if (SRAM_WE_N !== 1'b1) $display("FAIL reset_we_n: got %b want 1", SRAM_WE_N); else n_pass++;
    n_checks++; if (SRAM_OE_N !== 1'b1) $display("FAIL reset_oe_n: got %b want 1", SRAM_OE_N); else n_pass++;
    n_checks++; if (SRAM_ADDR !== '0) $display("FAIL reset_sram_addr: got %0h want 0", SRAM_ADDR); else n_pass++;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_store();
    int low, wel, oel; logic [31:0] rdv; bit to;
    ref_access(1'b1, BASE, 32'hDEADBEEF);
    do_access(1'b1, 1'b0, BASE, 32'hDEADBEEF, -1, low, wel, oel, rdv, to);
    n_checks++; if (to) $display("FAIL store_timeout: got no ready want ready"); else n_pass++;
    n_checks++; if (low != EXP_LOW) $display("FAIL store_ready_low: got %0d want %0d", low, EXP_LOW); else n_pass++;
    n_checks++; if (wel != EXP_WE) $display("FAIL store_we_low: got %0d want %0d", wel, EXP_WE); else n_pass++;
    n_checks++; if (oel != 0) $display("FAIL store_oe_low: got %0d want 0", oel); else n_pass++;
    n_checks++; if (sram[0] !== 16'hBEEF) $display("FAIL store_half0: got %04h want BEEF", sram[0]); else n_pass++;
    n_checks++; if (sram[1] !== 16'hDEAD) $display("FAIL store_half1: got %04h want DEAD", sram[1]); else n_pass++;
    n_checks++; if (rdv !== exp_rd) $display("FAIL store_read_data: got %08h want %08h", rdv, exp_rd); else n_pass++;
  endtask

  task automatic test_load();
    int low, wel, oel; logic [31:0] rdv; bit to;
    ref_access(1'b0, BASE, 32'h0);
    do_access(1'b0, 1'b1, BASE, $urandom, -1, low, wel, oel, rdv, to);
    n_checks++; if (to || low != EXP_LOW) $display("FAIL load_ready_low: got %0d (timeout %0b) want %0d", low, to, EXP_LOW); else n_pass++;
    n_checks++; if (wel != 0) $display("FAIL load_we_low: got %0d want 0", wel); else n_pass++;
    n_checks++; if (oel != EXP_OE) $display("FAIL load_oe_low: got %0d want %0d", oel, EXP_OE); else n_pass++;
    n_checks++; if (rdv !== 32'hDEADBEEF) $display("FAIL load_data: got %08h want DEADBEEF", rdv); else n_pass++;
    @(negedge clk);
    n_checks++; if (read_data !== 32'hDEADBEEF) $display("FAIL load_hold: got %08h want DEADBEEF", read_data); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort();
    logic [31:0] a;
    int w;
    a = BASE + 32'h800;
    w = word_idx(a);
    wr_en = 1'b1; address = a; write_data = 32'h1234_5678;
    repeat (P + 3) @(negedge clk);
    n_checks++; if (SRAM_WE_N !== 1'b0 || SRAM_ADDR !== AW'(2*w + 1))
      $display("FAIL abort_pre_hi: got we_n=%b addr=%0h want we_n=0 addr=%0h", SRAM_WE_N, SRAM_ADDR, 2*w + 1); else n_pass++;
    #2 rst = 1'b0;
    #1 probe = 1'b1;
    #1;
    n_checks++; if (SRAM_WE_N !== 1'b1) $display("FAIL abort_we_n: got %b want 1", SRAM_WE_N); else n_pass++;
    n_checks++; if (SRAM_OE_N !== 1'b1) $display("FAIL abort_oe_n: got %b want 1", SRAM_OE_N); else n_pass++;
    n_checks++; if (SRAM_DQ !== 16'h0000) $display("FAIL abort_dq_released: got %04h want 0000", SRAM_DQ); else n_pass++;
    n_checks++; if (ready !== 1'b0) $display("FAIL abort_ready_req: got %b want 0", ready); else n_pass++;
    n_checks++; if (read_data !== 32'h0) $display("FAIL abort_read_data: got %08h want 0", read_data); else n_pass++;
    wr_en = 1'b0;
    #1;
    n_checks++; if (ready !== 1'b1) $display("FAIL abort_ready_idle: got %b want 1", ready); else n_pass++;
    probe = 1'b0;
    exp_rd = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int low, wel, oel; logic [31:0] rdv, d; bit to;
    d = $urandom;
    ref_access(1'b1, BASE + 32'd8, d);
    do_access(1'b1, 1'b0, BASE + 32'd8, d, -1, low, wel, oel, rdv, to);
    n_checks++; if (to || low != EXP_LOW) $display("FAIL b2b_store_low: got %0d want %0d", low, EXP_LOW); else n_pass++;
    ref_access(1'b0, BASE + 32'd8, 32'h0);
    do_access(1'b0, 1'b1, BASE + 32'd8, 32'h0, -1, low, wel, oel, rdv, to);
    n_checks++; if (sram[4] !== d[15:0] || sram[5] !== d[31:16])
      $display("FAIL b2b_halves: got %04h_%04h want %08h", sram[5], sram[4], d); else n_pass++;
    n_checks++; if (to || low != EXP_LOW) $display("FAIL b2b_load_low: got %0d want %0d", low, EXP_LOW); else n_pass++;
    n_checks++; if (oel != EXP_OE) $display("FAIL b2b_load_oe: got %0d want %0d", oel, EXP_OE); else n_pass++;
    n_checks++; if (rdv !== exp_rd) $display("FAIL b2b_load_data: got %08h want %08h", rdv, exp_rd); else n_pass++;
  endtask

  task automatic test_both_enables();
    int low, wel, oel; logic [31:0] rdv, d; bit to;
    d = $urandom;
    ref_access(1'b1, BASE + 32'd4, d);
    do_access(1'b1, 1'b1, BASE + 32'd4, d, -1, low, wel, oel, rdv, to);
    n_checks++; if (to || low != EXP_LOW) $display("FAIL both_low: got %0d want %0d", low, EXP_LOW); else n_pass++;
    n_checks++; if (wel != EXP_WE || oel != 0) $display("FAIL both_strobes: got we %0d oe %0d want %0d 0", wel, oel, EXP_WE); else n_pass++;
    n_checks++; if (sram[2] !== d[15:0] || sram[3] !== d[31:16])
      $display("FAIL both_halves: got %04h_%04h want %08h", sram[3], sram[2], d); else n_pass++;
    n_checks++; if (rdv !== exp_rd) $display("FAIL both_read_data: got %08h want %08h", rdv, exp_rd); else n_pass++;
  endtask

  task automatic test_drop_and_wrap();
    int low, wel, oel, v0; logic [31:0] rdv, d; bit to;
    d = $urandom;
    v0 = we_viol;
    ref_access(1'b1, BASE - 32'd4, d);
    do_access(1'b1, 1'b0, BASE - 32'd4, d, 1, low, wel, oel, rdv, to);
    n_checks++; if (to || low != EXP_LOW) $display("FAIL drop_low: got %0d want %0d", low, EXP_LOW); else n_pass++;
    n_checks++; if (wel != EXP_WE) $display("FAIL drop_we_low: got %0d want %0d", wel, EXP_WE); else n_pass++;
    n_checks++; if (sram[18'h3FFFE] !== d[15:0] || sram[18'h3FFFF] !== d[31:16])
      $display("FAIL wrap_halves: got %04h_%04h want %08h", sram[18'h3FFFF], sram[18'h3FFFE], d); else n_pass++;
    n_checks++; if (we_viol != v0) $display("FAIL drop_we_window: got %0d violations want 0", we_viol - v0); else n_pass++;
  endtask

  task automatic test_random();
    int low, wel, oel, v0, kind, w;
    logic [31:0] rdv, a, d;
    logic wr, rd;
    bit to;
    int touched[$];
    v0 = we_viol;
    for (int t = 0; t < 24; t++) begin
      kind = $urandom_range(0, 2);
      wr = (kind != 0);
      rd = (kind != 1);
      if ($urandom_range(0, 7) == 0) a = BASE - 32'(4 * $urandom_range(1, 3));
      else a = BASE + 32'(4 * $urandom_range(0, 15));
      d = $urandom;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      ref_access(wr, a, d);
      touched.push_back(word_idx(a));
      do_access(wr, rd, a, d, -1, low, wel, oel, rdv, to);
      n_checks++; if (to || low != EXP_LOW) $display("FAIL rand%0d_low: got %0d want %0d", t, low, EXP_LOW); else n_pass++;
      n_checks++; if (wel != (wr ? EXP_WE : 0) || oel != (wr ? 0 : EXP_OE))
        $display("FAIL rand%0d_strobes: got we %0d oe %0d wr %0b", t, wel, oel, wr); else n_pass++;
      n_checks++; if (rdv !== exp_rd) $display("FAIL rand%0d_read_data: got %08h want %08h", t, rdv, exp_rd); else n_pass++;
    end
    foreach (touched[i]) begin
      w = touched[i];
      n_checks++; if (sram[2*w] !== ref_half(2*w) || sram[2*w + 1] !== ref_half(2*w + 1))
        $display("FAIL rand_mem_word%0h: got %04h_%04h want %04h_%04h", w, sram[2*w + 1], sram[2*w],
                 ref_half(2*w + 1), ref_half(2*w)); else n_pass++;
    end
    n_checks++; if (we_viol != v0) $display("FAIL rand_we_window: got %0d violations want 0", we_viol - v0); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_reset_abort();
    test_back_to_back();
    test_both_enables();
    test_drop_and_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
